// File: rtl/var_access_unit_pkg.sv
// Shared types for the Z-machine variable access engine: operation kind, FSM states,
// frame layout default and the variable number where globals begin.
package var_types;

  localparam int ADDR_W_DEFAULT    = 16;
  localparam int FRAME_HDR_DEFAULT = 4;
  localparam logic [7:0] V_GLOBAL_BASE = 8'h10;

  // Byte address type used by the rest of the register/memory slice.
  typedef logic [ADDR_W_DEFAULT-1:0] addr_t;

  typedef enum logic {
    VAR_READ  = 1'b0,
    VAR_WRITE = 1'b1
  } var_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RD_HI,
    S_RD_LO,
    S_WR_HI,
    S_WR_LO,
    S_RESP
  } var_state_t;

endpackage

// File: rtl/var_access_unit_addr_calc.sv
// Combinational resolver: maps variable V plus the frame/stack registers to a byte
// address, the SP value after the access, and the illegal-local / underflow error.
module var_addr_calc
  import var_types::*;
#(
  parameter int ADDR_W     = 16,
  parameter int NUM_LOCALS = 15,
  parameter int FRAME_HDR  = FRAME_HDR_DEFAULT
) (
  input  logic [7:0]        var_i,
  input  logic [ADDR_W-1:0] fp_i,
  input  logic [ADDR_W-1:0] gp_i,
  input  logic [ADDR_W-1:0] sp_i,
  input  logic [ADDR_W-1:0] sb_i,
  input  logic              write_i,
  input  logic              indir_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] sp_next_o,
  output logic              sp_upd_o,
  output logic              err_o
);

  localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

  logic [ADDR_W:0] sb_p1;
  logic            underflow;

  // Widened compare so sb near the top of memory cannot wrap into a false pass.
  assign sb_p1     = {1'b0, sb_i} + {{ADDR_W{1'b0}}, 1'b1};
  assign underflow = ({1'b0, sp_i} <= sb_p1);

  always_comb begin
    addr_o    = '0;
    sp_next_o = sp_i;
    sp_upd_o  = 1'b0;
    err_o     = 1'b0;
    if (var_i == 8'h00) begin
      if (write_i && !indir_i) begin
        addr_o    = sp_i;
        sp_next_o = sp_i + TWO;
        sp_upd_o  = 1'b1;
      end else begin
        addr_o = sp_i - TWO;
        err_o  = underflow;
        if (!indir_i) begin
          sp_next_o = sp_i - TWO;
          sp_upd_o  = 1'b1;
        end
      end
    end else if (var_i < V_GLOBAL_BASE) begin
      addr_o = fp_i + ADDR_W'(FRAME_HDR) + ADDR_W'({var_i - 8'd1, 1'b0});
      err_o  = (var_i > 8'(NUM_LOCALS));
    end else begin
      addr_o = gp_i + ADDR_W'({var_i - V_GLOBAL_BASE, 1'b0});
    end
  end

endmodule

// File: rtl/var_access_unit.sv
// Sequential variable access engine: accepts one variable read/write at a time and
// performs it as two big-endian byte accesses, reporting the word, errors and SP updates.
module var_access_unit
  import var_types::*;
#(
  parameter int ADDR_W     = 16,
  parameter int NUM_LOCALS = 15,
  parameter int FRAME_HDR  = FRAME_HDR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_indir,
  input  logic [7:0]        req_var,
  input  logic [15:0]       req_wdata,
  input  logic [ADDR_W-1:0] fp,
  input  logic [ADDR_W-1:0] gp,
  input  logic [ADDR_W-1:0] sp,
  input  logic [ADDR_W-1:0] sb,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              resp_valid,
  output logic [15:0]       resp_rdata,
  output logic              resp_err,
  output logic              sp_we,
  output logic [ADDR_W-1:0] sp_next
);

  var_state_t        state_q;
  logic [ADDR_W-1:0] addr_q, spn_q, mem_addr_q, sp_next_q;
  logic [7:0]        wdata_lo_q, rd_hi_q, mem_wdata_q;
  logic [15:0]       resp_rdata_q;
  logic              sp_upd_q, mem_req_q, mem_we_q, resp_valid_q, resp_err_q, sp_we_q;

  logic [ADDR_W-1:0] calc_addr_d, calc_spn_d;
  logic              calc_upd_d, calc_err_d;
  var_op_t           op_d;

  assign op_d = var_op_t'(req_write);

  var_addr_calc #(
    .ADDR_W    (ADDR_W),
    .NUM_LOCALS(NUM_LOCALS),
    .FRAME_HDR (FRAME_HDR)
  ) u_calc (
    .var_i    (req_var),
    .fp_i     (fp),
    .gp_i     (gp),
    .sp_i     (sp),
    .sb_i     (sb),
    .write_i  (req_write),
    .indir_i  (req_indir),
    .addr_o   (calc_addr_d),
    .sp_next_o(calc_spn_d),
    .sp_upd_o (calc_upd_d),
    .err_o    (calc_err_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      spn_q        <= '0;
      sp_upd_q     <= 1'b0;
      wdata_lo_q   <= '0;
      rd_hi_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      sp_we_q      <= 1'b0;
      sp_next_q    <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      sp_we_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q     <= calc_addr_d;
            spn_q      <= calc_spn_d;
            sp_upd_q   <= calc_upd_d;
            wdata_lo_q <= req_wdata[7:0];
            // Only erroring requests dwell in ADDR; good ones start the high byte
            // immediately so the first mem_req appears the cycle after accept.
            if (calc_err_d) begin
              state_q <= S_ADDR;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= (op_d == VAR_WRITE);
              mem_addr_q  <= calc_addr_d;
              mem_wdata_q <= req_wdata[15:8];
              state_q     <= (op_d == VAR_WRITE) ? S_WR_HI : S_RD_HI;
            end
          end
        end
        S_ADDR: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          resp_rdata_q <= '0;
          state_q      <= S_RESP;
        end
        S_RD_HI: begin
          if (mem_ack) begin
            rd_hi_q    <= mem_rdata;
            mem_addr_q <= addr_q + ADDR_W'(1);
            state_q    <= S_RD_LO;
          end
        end
        S_RD_LO: begin
          if (mem_ack) begin
            mem_req_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= {rd_hi_q, mem_rdata};
            sp_we_q      <= sp_upd_q;
            sp_next_q    <= spn_q;
            state_q      <= S_RESP;
          end
        end
        S_WR_HI: begin
          if (mem_ack) begin
            mem_addr_q  <= addr_q + ADDR_W'(1);
            mem_wdata_q <= wdata_lo_q;
            state_q     <= S_WR_LO;
          end
        end
        S_WR_LO: begin
          if (mem_ack) begin
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            sp_we_q      <= sp_upd_q;
            sp_next_q    <= spn_q;
            state_q      <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign sp_we      = sp_we_q;
  assign sp_next    = sp_next_q;

endmodule

// File: tb/tb_var_access_unit.sv
// Scoreboard bench for var_access_unit: directed requests push expected byte accesses
// and responses; independent monitors pop and compare as the DUT presents them.
module tb_var_access_unit;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    logic        spwe;
    logic [15:0] spn;
    int          lat;
  } resp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_indir = 1'b0;
  logic [7:0]  req_var = 8'h00;
  logic [15:0] req_wdata = 16'h0000;
  logic [15:0] fp = 16'h0, gp = 16'h0, sp = 16'h0, sb = 16'h0;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        resp_valid, resp_err, sp_we;
  logic [15:0] resp_rdata, sp_next;

  logic [7:0]  mem [0:65535];
  int          wcnt = 0, ack_dly = 0, cyc = 0, last_acc = 0;
  int          n_cmp = 0, n_fail = 0;
  resp_t       exp_resp[$];
  acc_t        exp_acc[$];

  var_access_unit #(.ADDR_W(16), .NUM_LOCALS(4), .FRAME_HDR(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_indir(req_indir), .req_var(req_var), .req_wdata(req_wdata),
    .fp(fp), .gp(gp), .sp(sp), .sb(sb),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sp_we(sp_we), .sp_next(sp_next)
  );

  always #5 clk = ~clk;

  // Byte memory with a programmable number of wait cycles before each ack.
  assign mem_ack   = mem_req && (wcnt >= ack_dly);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
    if (mem_req && mem_we && mem_ack) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: memory accesses and responses, independent of the stimulus thread.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_req) begin
        if (exp_acc.size() == 0) chk("unexpected_mem_req", 32'(mem_req), 32'd0);
        else begin
          chk("mem_addr", 32'(mem_addr), 32'(exp_acc[0].addr));
          chk("mem_we", 32'(mem_we), 32'(exp_acc[0].we));
          if (exp_acc[0].we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_acc[0].wdata));
          if (mem_ack) void'(exp_acc.pop_front());
        end
      end
      if (resp_valid) begin
        if (exp_resp.size() == 0) chk("unexpected_resp", 32'(resp_valid), 32'd0);
        else begin
          resp_t r;
          r = exp_resp.pop_front();
          chk("resp_rdata", 32'(resp_rdata), 32'(r.rdata));
          chk("resp_err", 32'(resp_err), 32'(r.err));
          chk("sp_we", 32'(sp_we), 32'(r.spwe));
          if (r.spwe) chk("sp_next", 32'(sp_next), 32'(r.spn));
          chk("latency", 32'(cyc - last_acc + 1), 32'(r.lat));
        end
      end else if (sp_we) chk("sp_we_without_resp", 32'(sp_we), 32'd0);
    end
  end

  task automatic exp_rd(input logic [15:0] a);
    exp_acc.push_back('{we: 1'b0, addr: a, wdata: 8'h00});
    exp_acc.push_back('{we: 1'b0, addr: a + 16'd1, wdata: 8'h00});
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [15:0] d);
    exp_acc.push_back('{we: 1'b1, addr: a, wdata: d[15:8]});
    exp_acc.push_back('{we: 1'b1, addr: a + 16'd1, wdata: d[7:0]});
  endtask

  task automatic exp_rsp(input logic [15:0] rd, input logic e, input logic w,
                         input logic [15:0] n, input int lat);
    exp_resp.push_back('{rdata: rd, err: e, spwe: w, spn: n, lat: lat});
  endtask

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic issue(input logic wr, input logic ind, input logic [7:0] v, input logic [15:0] wd,
                       input logic [15:0] f, input logic [15:0] g, input logic [15:0] s,
                       input logic [15:0] b);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(req_ready), 32'd1);
    req_write = wr; req_indir = ind; req_var = v; req_wdata = wd;
    fp = f; gp = g; sp = s; sb = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    last_acc  = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_resp.size() != 0 || exp_acc.size() != 0) && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 60) chk("done_timeout", 32'(exp_resp.size() + exp_acc.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1008] = 8'h12; mem[16'h1009] = 8'h34;
    mem[16'hFFFF] = 8'hAB; mem[16'h0000] = 8'hCD;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_sp_we", 32'(sp_we), 32'd0);
    chk("rst_sp_next", 32'(sp_next), 32'd0);
    @(posedge clk); #1;

    // Local 3: fp+4+2*2 = 0x1008
    exp_rd(16'h1008); exp_rsp(16'h1234, 1'b0, 1'b0, 16'h0, 3);
    issue(1'b0, 1'b0, 8'h03, 16'h0, 16'h1000, 16'h0, 16'h0, 16'h0); wait_done();
    // Global 0x12: gp+4
    exp_wr(16'h2004, 16'hBEEF); exp_rsp(16'h0000, 1'b0, 1'b0, 16'h0, 3);
    issue(1'b1, 1'b0, 8'h12, 16'hBEEF, 16'h0, 16'h2000, 16'h0, 16'h0); wait_done();
    // Push then pop
    exp_wr(16'h3000, 16'h0042); exp_rsp(16'h0000, 1'b0, 1'b1, 16'h3002, 3);
    issue(1'b1, 1'b0, 8'h00, 16'h0042, 16'h0, 16'h0, 16'h3000, 16'h2F00); wait_done();
    exp_rd(16'h3000); exp_rsp(16'h0042, 1'b0, 1'b1, 16'h3000, 3);
    issue(1'b0, 1'b0, 8'h00, 16'h0, 16'h0, 16'h0, 16'h3002, 16'h2F00); wait_done();
    // Underflow pop and illegal local: no memory access, error at T+2
    exp_rsp(16'h0000, 1'b1, 1'b0, 16'h0, 2);
    issue(1'b0, 1'b0, 8'h00, 16'h0, 16'h0, 16'h0, 16'h3000, 16'h3000); wait_done();
    exp_rsp(16'h0000, 1'b1, 1'b0, 16'h0, 2);
    issue(1'b0, 1'b0, 8'h05, 16'h0, 16'h1000, 16'h0, 16'h0, 16'h0); wait_done();
    // Peek and replace leave SP alone
    exp_rd(16'h3000); exp_rsp(16'h0042, 1'b0, 1'b0, 16'h0, 3);
    issue(1'b0, 1'b1, 8'h00, 16'h0, 16'h0, 16'h0, 16'h3002, 16'h2F00); wait_done();
    exp_wr(16'h3000, 16'hA55A); exp_rsp(16'h0000, 1'b0, 1'b0, 16'h0, 3);
    issue(1'b1, 1'b1, 8'h00, 16'hA55A, 16'h0, 16'h0, 16'h3002, 16'h2F00); wait_done();
    // Replace with sp = sb+1 is an underflow
    exp_rsp(16'h0000, 1'b1, 1'b0, 16'h0, 2);
    issue(1'b1, 1'b1, 8'h00, 16'h1111, 16'h0, 16'h0, 16'h3001, 16'h3000); wait_done();
    // Wrap: local 1 at 0xFFFF, low byte at 0x0000; push at 0xFFFE wraps SP to 0
    exp_rd(16'hFFFF); exp_rsp(16'hABCD, 1'b0, 1'b0, 16'h0, 3);
    issue(1'b0, 1'b0, 8'h01, 16'h0, 16'hFFFB, 16'h0, 16'h0, 16'h0); wait_done();
    exp_wr(16'hFFFE, 16'h1357); exp_rsp(16'h0000, 1'b0, 1'b1, 16'h0000, 3);
    issue(1'b1, 1'b0, 8'h00, 16'h1357, 16'h0, 16'h0, 16'hFFFE, 16'hF000); wait_done();

    // Three wait cycles per byte, with a request waved at the busy unit
    ack_dly = 3;
    exp_rd(16'h1008); exp_rsp(16'h1234, 1'b0, 1'b0, 16'h0, 9);
    issue(1'b0, 1'b0, 8'h03, 16'h0, 16'h1000, 16'h0, 16'h0, 16'h0);
    req_valid = 1'b1; req_write = 1'b1; req_var = 8'h12; req_wdata = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("busy_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1 req_valid = 1'b0;
    wait_done();

    // Reset while the low byte of a read is waiting for its ack
    exp_rd(16'h1008);
    issue(1'b0, 1'b0, 8'h03, 16'h0, 16'h1000, 16'h0, 16'h0, 16'h0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rdlo_mem_addr", 32'(mem_addr), 32'h1009);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_acc.delete();
    @(negedge clk);
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;

    chk("mem_2004", 32'(mem[16'h2004]), 32'hBE);
    chk("mem_2005", 32'(mem[16'h2005]), 32'hEF);
    chk("mem_3000", 32'(mem[16'h3000]), 32'hA5);
    chk("mem_3001", 32'(mem[16'h3001]), 32'h5A);
    chk("mem_fffe", 32'(mem[16'hFFFE]), 32'h13);
    chk("mem_ffff", 32'(mem[16'hFFFF]), 32'h57);
    chk("left_resp", 32'(exp_resp.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
